// File: rtl/ttt_core_scheduler.sv
// ttt_core_scheduler: per-processor token buffering and time-multiplexed sweep of the shared TTT core.
// Latency: an accepted event is visible at any PRESENT one cycle later; a sweep is 1 + 2*NUM_PROCESSORS cycles plus stalls.
// Backpressure: in_ready is high whenever out of reset; a full 1-entry output register stalls the sweep in CAPTURE.
// Optional macro TTT_SCHED_PROG_EN adds the programming port and the PROG state.
module ttt_core_scheduler #(
    parameter int NEW_TOKEN_BITS = 8,
    parameter int TOKEN_BITS     = 8,
    parameter int DURATION_BITS  = 8,
    parameter int NUM_PROCESSORS = 10,
    parameter int TICK_CYCLES    = 64,
    parameter int IW             = $clog2(NUM_PROCESSORS)
) (
    input  logic                      clock_fast,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IW-1:0]             in_id,
    input  logic                      in_good,
    output logic                      clock_slow,
    output logic [IW-1:0]             processor_id,
    output logic [NEW_TOKEN_BITS-1:0] new_good_tokens,
    output logic [NEW_TOKEN_BITS-1:0] new_bad_tokens,
    output logic [2:0]                instruction,
    output logic [DURATION_BITS-1:0]  prog_duration,
    output logic [TOKEN_BITS-1:0]     prog_threshold,
    input  logic [1:0]                token_startstop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IW-1:0]             out_id,
    output logic [1:0]                out_startstop,
    input  logic                      prog_valid,
    output logic                      prog_ready,
    input  logic [IW-1:0]             prog_id,
    input  logic [2:0]                prog_instr,
    input  logic [DURATION_BITS-1:0]  prog_dur,
    input  logic [TOKEN_BITS-1:0]     prog_thr,
    output logic                      tick_overrun
);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [NEW_TOKEN_BITS-1:0] CNT_MAX = '1;
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_PROCESSORS - 1);

    typedef enum logic [2:0] {S_IDLE, S_TICK, S_PRESENT, S_CAPTURE, S_PROG} state_t;

    state_t                    state, state_nxt;
    logic [IW-1:0]             k, k_nxt;
    logic [NEW_TOKEN_BITS-1:0] good_cnt [NUM_PROCESSORS];
    logic [NEW_TOKEN_BITS-1:0] bad_cnt  [NUM_PROCESSORS];
    logic [NUM_PROCESSORS-1:0] present_clr;
    logic [TW-1:0]             tick_cnt;
    logic                      tick_due, tick_pending, take_tick;
    logic                      accept, out_full, load_out;

    assign in_ready    = reset;
    assign accept      = in_valid & reset;
    assign tick_due    = (tick_cnt == TW'(TICK_CYCLES - 1));
    assign take_tick   = tick_due | tick_pending;
    assign out_full    = out_valid & ~out_ready;
    assign present_clr = (state == S_PRESENT) ? (NUM_PROCESSORS'(1) << k) : '0;

    function automatic logic [NEW_TOKEN_BITS-1:0] bump(input logic [NEW_TOKEN_BITS-1:0] v);
        return (v == CNT_MAX) ? v : v + NEW_TOKEN_BITS'(1);
    endfunction

    // A clear and an increment in the same cycle leave the counter at 1.
    always_ff @(posedge clock_fast) begin
        for (int i = 0; i < NUM_PROCESSORS; i++) begin
            if (!reset) begin
                good_cnt[i] <= '0;
                bad_cnt[i]  <= '0;
            end else begin
                if (accept && in_good && in_id == IW'(i))
                    good_cnt[i] <= bump(present_clr[i] ? '0 : good_cnt[i]);
                else if (present_clr[i])
                    good_cnt[i] <= '0;
                if (accept && !in_good && in_id == IW'(i))
                    bad_cnt[i] <= bump(present_clr[i] ? '0 : bad_cnt[i]);
                else if (present_clr[i])
                    bad_cnt[i] <= '0;
            end
        end
    end

    always_ff @(posedge clock_fast) begin
        if (!reset) begin
            tick_cnt      <= '0;
            state         <= S_IDLE;
            k             <= '0;
            tick_pending  <= 1'b0;
            tick_overrun  <= 1'b0;
            out_valid     <= 1'b0;
            out_id        <= '0;
            out_startstop <= '0;
        end else begin
            tick_cnt <= tick_due ? '0 : tick_cnt + TW'(1);
            state    <= state_nxt;
            k        <= k_nxt;
            // Leaving IDLE always consumes any remembered tick.
            if (state == S_IDLE)
                tick_pending <= 1'b0;
            else if (tick_due)
                tick_pending <= 1'b1;
            if (tick_due && state != S_IDLE)
                tick_overrun <= 1'b1;
            if (load_out) begin
                out_valid     <= 1'b1;
                out_id        <= k;
                out_startstop <= token_startstop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        k_nxt           = k;
        load_out        = 1'b0;
        clock_slow      = 1'b0;
        processor_id    = '0;
        new_good_tokens = '0;
        new_bad_tokens  = '0;
        instruction     = '0;
        prog_duration   = '0;
        prog_threshold  = '0;
        prog_ready      = 1'b0;
        case (state)
            S_IDLE: begin
                if (take_tick)
                    state_nxt = S_TICK;
`ifdef TTT_SCHED_PROG_EN
                else if (prog_valid)
                    state_nxt = S_PROG;
`endif
            end
            S_TICK: begin
                clock_slow = 1'b1;
                k_nxt      = '0;
                state_nxt  = S_PRESENT;
            end
            S_PRESENT: begin
                processor_id    = k;
                new_good_tokens = good_cnt[k];
                new_bad_tokens  = bad_cnt[k];
                state_nxt       = S_CAPTURE;
            end
            S_CAPTURE: begin
                processor_id = k;
                if (!out_full) begin
                    load_out = (token_startstop != 2'b00);
                    if (k == LAST_ID) begin
                        state_nxt = S_IDLE;
                    end else begin
                        k_nxt     = k + IW'(1);
                        state_nxt = S_PRESENT;
                    end
                end
            end
`ifdef TTT_SCHED_PROG_EN
            S_PROG: begin
                processor_id   = prog_id;
                instruction    = prog_instr;
                prog_duration  = prog_dur;
                prog_threshold = prog_thr;
                prog_ready     = 1'b1;
                state_nxt      = S_IDLE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

`ifndef TTT_SCHED_PROG_EN
    logic unused_prog;
    assign unused_prog = ^{prog_valid, prog_id, prog_instr, prog_dur, prog_thr};
`endif

endmodule

// File: tb/tb_ttt_core_scheduler.sv
// Scoreboard bench for ttt_core_scheduler: count model per processor, queue of expected output events.
module tb_ttt_core_scheduler;
    localparam int NTB  = 8;
    localparam int NP   = 10;
    localparam int IW   = 4;
    localparam int TC   = 64;
    localparam int CMAX = (1 << NTB) - 1;

    logic           clock_fast = 1'b0;
    logic           reset;
    logic           in_valid, in_ready, in_good;
    logic [IW-1:0]  in_id;
    logic           clock_slow;
    logic [IW-1:0]  processor_id;
    logic [NTB-1:0] new_good_tokens, new_bad_tokens;
    logic [2:0]     instruction;
    logic [7:0]     prog_duration, prog_threshold;
    logic [1:0]     token_startstop;
    logic           out_valid, out_ready;
    logic [IW-1:0]  out_id;
    logic [1:0]     out_startstop;
    logic           prog_valid, prog_ready;
    logic [IW-1:0]  prog_id;
    logic [2:0]     prog_instr;
    logic [7:0]     prog_dur, prog_thr;
    logic           tick_overrun;

    always #5 clock_fast = ~clock_fast;

    ttt_core_scheduler #(
        .NEW_TOKEN_BITS(NTB), .TOKEN_BITS(8), .DURATION_BITS(8),
        .NUM_PROCESSORS(NP), .TICK_CYCLES(TC), .IW(IW)
    ) dut (
        .clock_fast(clock_fast), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_good(in_good),
        .clock_slow(clock_slow), .processor_id(processor_id),
        .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
        .instruction(instruction), .prog_duration(prog_duration), .prog_threshold(prog_threshold),
        .token_startstop(token_startstop),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_startstop(out_startstop),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_id(prog_id),
        .prog_instr(prog_instr), .prog_dur(prog_dur), .prog_thr(prog_thr),
        .tick_overrun(tick_overrun)
    );

    // Core stand-in: fixed response per selected processor.
    logic [1:0] core_resp [NP];
    always_comb token_startstop = (int'(processor_id) < NP) ? core_resp[processor_id] : 2'b00;

    typedef struct { int id; int ss; } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_good [NP];
    int mdl_bad  [NP];
    int pres_good[NP];
    int pres_bad [NP];
    int cyc = 0;
    int phase = 0, mk = 0, sweeps = 0, sweep_end_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clock_fast) cyc <= cyc + 1;

    // Sweep tracker and output scoreboard, sampled on the falling edge.
    always @(negedge clock_fast) begin
        if (!reset) begin
            phase = 0;
            mk    = 0;
        end else begin
            if (out_valid && out_ready) begin
                chk("out_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("out_id", 32'(out_id), e.id);
                    chk("out_ss", 32'(out_startstop), e.ss);
                end
            end
            case (phase)
                0: begin
                    if ((new_good_tokens | new_bad_tokens) != 0)
                        chk("idle_tokens", 32'(new_good_tokens | new_bad_tokens), 0);
                    if (clock_slow) begin
                        phase = 1;
                        mk    = 0;
                    end
                end
                1: begin
                    chk("pres_id", 32'(processor_id), mk);
                    chk("pres_good", 32'(new_good_tokens), mdl_good[mk]);
                    chk("pres_bad", 32'(new_bad_tokens), mdl_bad[mk]);
                    pres_good[mk] = int'(new_good_tokens);
                    pres_bad[mk]  = int'(new_bad_tokens);
                    mdl_good[mk]  = 0;
                    mdl_bad[mk]   = 0;
                    phase = 2;
                end
                default: begin
                    if (!(out_valid && !out_ready)) begin
                        if (mk == NP - 1) begin
                            phase = 0;
                            sweeps++;
                            sweep_end_cyc = cyc;
                        end else begin
                            mk++;
                            phase = 1;
                        end
                    end
                end
            endcase
        end
    end

    task automatic send(input int id, input bit good, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_id    = id[IW-1:0];
            in_good  = good;
            @(posedge clock_fast);
            if (id < NP) begin
                if (good && mdl_good[id] < CMAX) mdl_good[id]++;
                if (!good && mdl_bad[id] < CMAX) mdl_bad[id]++;
            end
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sweeps(input int n);
        int target = sweeps + n;
        int budget = 0;
        while (sweeps < target && budget < 1000) begin
            @(posedge clock_fast);
            budget++;
        end
        chk("sweep_done", sweeps, target);
        #1;
    endtask

    function automatic logic sel_sig(input int which);
        case (which)
            0:       return clock_slow;
            1:       return out_valid;
            default: return prog_ready;
        endcase
    endfunction

    task automatic wait_high(input string tag, input int which);
        int n = 0;
        do begin
            @(negedge clock_fast);
            n++;
        end while (!sel_sig(which) && n < 400);
        chk(tag, 32'(sel_sig(which)), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nz;
        reset = 1'b0; in_valid = 1'b0; in_id = '0; in_good = 1'b0; out_ready = 1'b1;
        prog_valid = 1'b0; prog_id = '0; prog_instr = '0; prog_dur = '0; prog_thr = '0;
        for (int i = 0; i < NP; i++) begin
            core_resp[i] = 2'b00; mdl_good[i] = 0; mdl_bad[i] = 0;
        end

        // Reset state and quiet first tick period.
        repeat (3) @(posedge clock_fast);
        @(negedge clock_fast);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_outputs", 32'({clock_slow, out_valid, prog_ready, tick_overrun, processor_id, instruction}), 0);
        @(posedge clock_fast); #1;
        reset = 1'b1;
        nz = 0;
        for (int c = 0; c < TC; c++) begin
            @(negedge clock_fast);
            if (clock_slow || out_valid || processor_id != 0 || new_good_tokens != 0 ||
                new_bad_tokens != 0 || instruction != 0 || prog_ready || tick_overrun) nz++;
        end
        chk("pre_tick_quiet", nz, 0);
        chk("in_ready_up", 32'(in_ready), 1);
        @(negedge clock_fast);
        chk("first_tick", 32'(clock_slow), 1);
        @(posedge clock_fast); #1;
        wait_sweeps(1);

        // Accumulate to id 4, plus out-of-range ids that must be dropped.
        send(4, 1'b1, 3);
        send(4, 1'b0, 2);
        send(15, 1'b1, 2);
        send(11, 1'b0, 1);
        wait_sweeps(1);
        chk("acc_good4", pres_good[4], 3);
        chk("acc_bad4", pres_bad[4], 2);
        wait_sweeps(1);
        chk("clr_good4", pres_good[4], 0);
        chk("clr_bad4", pres_bad[4], 0);

        // Output stall: ids 1 and 2 report 01, consumer blocked.
        core_resp[1] = 2'b01;
        core_resp[2] = 2'b01;
        exp_q.push_back('{1, 1});
        exp_q.push_back('{2, 1});
        out_ready = 1'b0;
        wait_high("stall_out_valid", 1);
        repeat (10) @(negedge clock_fast);
        chk("stall_hold_valid", 32'(out_valid), 1);
        chk("stall_hold_id", 32'(out_id), 1);
        chk("stall_hold_ss", 32'(out_startstop), 1);
        chk("stall_pid", 32'(processor_id), 2);
        @(posedge clock_fast); #1;
        out_ready = 1'b1;
        wait_sweeps(1);
        chk("stall_q_empty", exp_q.size(), 0);
        core_resp[1] = 2'b00;
        core_resp[2] = 2'b00;
        chk("no_overrun_yet", 32'(tick_overrun), 0);

`ifdef TTT_SCHED_PROG_EN
        wait_high("prog_tick", 0);
        @(posedge clock_fast); #1;
        prog_valid = 1'b1; prog_id = 4'd7; prog_instr = 3'd3; prog_dur = 8'd20; prog_thr = 8'd5;
        wait_high("prog_ack", 2);
        chk("prog_slot", cyc - sweep_end_cyc, 2);
        chk("prog_pid", 32'(processor_id), 7);
        chk("prog_instr", 32'(instruction), 3);
        chk("prog_dur", 32'(prog_duration), 20);
        chk("prog_thr", 32'(prog_threshold), 5);
        @(posedge clock_fast); #1;
        prog_valid = 1'b0;
        @(negedge clock_fast);
        chk("prog_pulse", 32'(prog_ready), 0);
        chk("prog_nop", 32'(instruction), 0);
        @(posedge clock_fast); #1;
`else
        prog_valid = 1'b1; prog_id = 4'd7; prog_instr = 3'd3; prog_dur = 8'd20; prog_thr = 8'd5;
        nz = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock_fast);
            if (prog_ready || instruction != 0 || prog_duration != 0 || prog_threshold != 0) nz++;
        end
        chk("prog_disabled", nz, 0);
        @(posedge clock_fast); #1;
        prog_valid = 1'b0;
`endif

        // Overrun + saturation: stall at id 1 while 300 good events hit id 0.
        core_resp[0] = 2'b10;
        exp_q.push_back('{0, 2});
        out_ready = 1'b0;
        wait_high("ovr_tick", 0);
        wait_high("ovr_out_valid", 1);
        @(posedge clock_fast); #1;
        core_resp[0] = 2'b00;
        send(0, 1'b1, 300);
        @(negedge clock_fast);
        chk("overrun_set", 32'(tick_overrun), 1);
        chk("overrun_pid", 32'(processor_id), 1);
        @(posedge clock_fast); #1;
        out_ready = 1'b1;
        wait_sweeps(1);
        wait_high("pending_tick", 0);
        chk("pending_tick_slot", cyc - sweep_end_cyc, 2);
        @(posedge clock_fast); #1;
        wait_sweeps(1);
        chk("sat_good0", pres_good[0], CMAX);
        chk("overrun_sticky", 32'(tick_overrun), 1);
        chk("final_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ttt_core_scheduler.md
# ttt_core_scheduler

Time-multiplexing sequencer for the shared TTT processor core. It buffers incoming good/bad token events per processor and generates the slow tick. Each tick it sweeps `processor_id` over all processors, presenting each one's accumulated token counts. It captures the core's `token_startstop` result into an output event stream and, between sweeps, inserts programming writes to the core.

## Interface
Parameters:
- `NEW_TOKEN_BITS`, 8, width of per-processor accumulated good/bad counts
- `TOKEN_BITS`, 8, width of threshold programming field
- `DURATION_BITS`, 8, width of duration programming field
- `NUM_PROCESSORS`, 10, processors multiplexed on the core; ID width `IW = $clog2(NUM_PROCESSORS)`
- `TICK_CYCLES`, 64, fast cycles per slow tick; must be ≥ 2*NUM_PROCESSORS+4

Ports:
- `clock_fast`  in  1  sole clock
- `reset`  in  1  synchronous, active-low
- `in_valid` / `in_ready`  in / out  1 / 1  token-event handshake
- `in_id`  in  IW  target processor
- `in_good`  in  1  1 = good token, 0 = bad token
- `clock_slow`  out  1  one-cycle tick pulse to core
- `processor_id`  out  IW  core select
- `new_good_tokens` / `new_bad_tokens`  out  NEW_TOKEN_BITS  counts for selected processor, 0 when not sweeping
- `instruction`  out  3  core instruction, 0 (NOP) except during PROG
- `prog_duration`  out  DURATION_BITS  core programming data
- `prog_threshold`  out  TOKEN_BITS  core programming data
- `token_startstop`  in  2  core result for selected processor
- `out_valid` / `out_ready`  out / in  1 / 1  result-event handshake
- `out_id`  out  IW  processor that produced event
- `out_startstop`  out  2  captured nonzero `token_startstop`
- `prog_valid` / `prog_ready`  in / out  1 / 1  programming-request handshake
- `prog_id`, `prog_instr`, `prog_dur`, `prog_thr`  in  IW, 3, DURATION_BITS, TOKEN_BITS  programming request fields
- `tick_overrun`  out  1  sticky; tick came due while not IDLE

## Operation
- Per processor: good and bad counters, NEW_TOKEN_BITS each, saturating at all-ones.
- `in_ready` = 1 whenever `reset` is high. An accepted event increments the counter selected by `in_id`/`in_good`. An `in_id` ≥ NUM_PROCESSORS is accepted and dropped.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. A tick is due at wrap.
- FSM states: IDLE, TICK, PRESENT, CAPTURE, PROG.
- IDLE → TICK on tick due. Tick has priority over a pending prog request.
- IDLE → PROG on `prog_valid` with no tick due.
- TICK: `clock_slow`=1 for one cycle, then k=0 and → PRESENT.
- PRESENT: drive `processor_id`=k with processor k's counts. Both counters of k clear at the end of this cycle. → CAPTURE.
- CAPTURE: sample `token_startstop`.
  - If nonzero, load the output register (`out_id`=k).
  - If the output register is still full (`out_valid` & !`out_ready`), stall in CAPTURE holding `processor_id`=k.
  - Otherwise k+1 → PRESENT, or IDLE after k=NUM_PROCESSORS-1.
- PROG: one cycle.
  - Drive `processor_id`=`prog_id`, `instruction`=`prog_instr`, `prog_duration`/`prog_threshold` from the request.
  - `prog_ready`=1 that cycle. → IDLE.
- Tick due in a non-IDLE state: set `tick_overrun`, remember the tick as pending, and take it at the next IDLE.
- An event to processor k in the same cycle as its PRESENT clear leaves the counter at 1; it counts toward the next tick.

## Timing
- Reset values: all counters 0, FSM IDLE, tick counter 0, `out_valid`=0, `clock_slow`=0, `processor_id`=0, all token/prog outputs 0, `prog_ready`=0, `tick_overrun`=0. `in_ready`=0 while `reset` is low.
- Reset low mid-sweep aborts immediately. Pending events and counts are lost.
- Output register is 1 entry. `out_valid` rises the cycle after a nonzero CAPTURE and holds, with stable data, until `out_ready`.
- Nominal sweep length: 1 (TICK) + 2*NUM_PROCESSORS cycles, plus output stalls.
- Event accepted in cycle t is visible in `new_*_tokens` at any PRESENT at t+1 or later.
- `prog_ready` is a single-cycle pulse. The request must hold until acknowledged.

## Configuration
- `TTT_SCHED_PROG_EN`
  - Defined: programming port and PROG state present.
  - Undefined: PROG removed, `prog_ready` tied 0, `instruction`/`prog_duration`/`prog_threshold` constant 0, `prog_*` inputs ignored.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, release → no `clock_slow` until cycle TICK_CYCLES. All outputs stay 0 until then.
- Accumulate: send 3 good + 2 bad events to id 4 → at id-4 PRESENT, `new_good_tokens`=3, `new_bad_tokens`=2. At the next tick both are 0.
- Saturate: send 300 good events to id 0 with NEW_TOKEN_BITS=8 → presented count is 255.
- Output stall: core returns 2'b01 for ids 1 and 2, `out_ready`=0 for 10 cycles → event (1, 01) is held. Sweep stalls in CAPTURE at id 2. After `out_ready`=1, events (1, 01) then (2, 01) are delivered.
- Programming: assert `prog_valid` (id 7, instr 3, dur 20, thr 5) during a sweep → accepted in the first IDLE cycle after the sweep, with core pins showing exactly those values for one cycle.
- Overrun: hold `out_ready`=0 across a tick boundary → `tick_overrun`=1. The pending tick is issued at the next IDLE.
